ram_local_responder: RTL and testbench

Synthesizable stand-in for the DDR2 controller's local-side interface, backed by on-chip block RAM. It answers the same read/write/ready/rdata_valid handshake the memory front-end drives. It emulates init delay, fixed read latency and periodic refresh stalls. It lets the DAQ memory path be built and verified on boards or benches without the external RAM or vendor PHY.

---
 rtl/ram_local_pkg.sv | 25 ++
 rtl/ram_local_bram.sv | 36 +++
 rtl/ram_local_responder.sv | 168 ++++++++++++++++
 tb/tb_ram_local_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_local_pkg.sv
// Shared widths and state encodings for the local-side memory interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_local_pkg;

    localparam int LOCAL_ADDR_W = 25;
    localparam int LOCAL_DATA_W = 32;
    localparam int LOCAL_BE_W   = 4;

    localparam logic [2:0] SIZE_ONE = 3'd1;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    // Largest of three counts, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ram_local_bram.sv
// Single-port byte-enabled block RAM, write-first, no reset on contents.
// Latency: 1 cycle from enabled access to rdata.
// Backpressure: none; every enabled access is serviced that cycle.
module ram_local_bram
    import ram_local_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = LOCAL_DATA_W,
    parameter int BE_W   = LOCAL_BE_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Per-byte write-first port: a written byte is echoed, others read the array.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (we && be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    rdata[8*b +: 8]     <= wdata[8*b +: 8];
                end else begin
                    rdata[8*b +: 8]     <= mem[addr][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ram_local_responder.sv
// BRAM-backed stand-in for the DDR2 local interface with init delay and refresh stalls.
// Latency: read data valid READ_LATENCY cycles after acceptance; writes commit at acceptance.
// Backpressure: local_ready low during INIT and REFRESH; requester holds its request.
module ram_local_responder
    import ram_local_pkg::*;
#(
    parameter int DEPTH_LOG2       = 10,
    parameter int INIT_CYCLES      = 16,
    parameter int READ_LATENCY     = 3,    // legal range 2..8
    parameter int REFRESH_INTERVAL = 200,  // 0 disables refresh
    parameter int REFRESH_CYCLES   = 8     // at least 1
) (
    input  logic                    phy_clk,
    input  logic                    reset_n,
    input  logic [LOCAL_ADDR_W-1:0] local_address,
    input  logic                    local_write_req,
    input  logic                    local_read_req,
    input  logic                    local_burstbegin,
    input  logic [LOCAL_DATA_W-1:0] local_wdata,
    input  logic [LOCAL_BE_W-1:0]   local_be,
    input  logic [2:0]              local_size,
    output logic                    local_ready,
    output logic [LOCAL_DATA_W-1:0] local_rdata,
    output logic                    local_rdata_valid,
    output logic                    local_init_done,
    output logic                    local_refresh_ack,
    output logic [1:0]              err_flags
);

    localparam int CNT_MAX = max3(INIT_CYCLES, REFRESH_INTERVAL, REFRESH_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] INIT_END = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [CNT_W-1:0] REF_END  = CNT_W'(REFRESH_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wr_acc, rd_acc;
    logic [LOCAL_DATA_W-1:0] ram_q;
    logic [READ_LATENCY-1:0] vpipe;
    logic [LOCAL_DATA_W-1:0] dpipe [1:READ_LATENCY-1];

    // Burst-begin and upper address bits carry no meaning for this model.
    logic unused_inputs;
    assign unused_inputs = ^{local_burstbegin, local_address[LOCAL_ADDR_W-1:DEPTH_LOG2]};

    // A write wins over a simultaneous read; the read is dropped, not queued.
    assign wr_acc = local_ready && local_write_req;
    assign rd_acc = local_ready && local_read_req && !local_write_req;

    // One counter serves all three phases; it is cleared on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
                if (cnt == INIT_END) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (REFRESH_INTERVAL != 0) begin
                    if (cnt == ACT_END) begin
                        state_nxt = ST_REFRESH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            ST_REFRESH: begin
                if (cnt == REF_END) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and the registered ready/init_done that follow the next state.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_INIT;
            cnt             <= '0;
            local_ready     <= 1'b0;
            local_init_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            local_ready <= (state_nxt == ST_ACTIVE);
            if (state_nxt == ST_ACTIVE) begin
                local_init_done <= 1'b1;
            end
        end
    end

    assign local_refresh_ack = (state == ST_REFRESH) && (cnt == REF_END);

    // Protocol misuse flags stay set until the next reset.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flags <= 2'b00;
        end else begin
            if ((wr_acc || rd_acc) && (local_size != SIZE_ONE)) begin
                err_flags[0] <= 1'b1;
            end
            if (wr_acc && local_read_req) begin
                err_flags[1] <= 1'b1;
            end
        end
    end

    ram_local_bram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (LOCAL_DATA_W),
        .BE_W   (LOCAL_BE_W)
    ) u_bram (
        .clk   (phy_clk),
        .en    (wr_acc || rd_acc),
        .we    (wr_acc),
        .be    (local_be),
        .addr  (local_address[DEPTH_LOG2-1:0]),
        .wdata (local_wdata),
        .rdata (ram_q)
    );

    // Valid tokens are flushed by reset so in-flight reads never complete.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[READ_LATENCY-2:0], rd_acc};
        end
    end

    // Data stages track the valid stages; the RAM output register is stage zero.
    always_ff @(posedge phy_clk) begin
        dpipe[1] <= ram_q;
        for (int i = 2; i < READ_LATENCY; i++) begin
            dpipe[i] <= dpipe[i-1];
        end
    end

    // Final output stage; rdata holds its last value between valid pulses.
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            local_rdata_valid <= 1'b0;
            local_rdata       <= '0;
        end else begin
            local_rdata_valid <= vpipe[READ_LATENCY-1];
            if (vpipe[READ_LATENCY-1]) begin
                local_rdata <= dpipe[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_local_responder.sv
// Randomized and directed checks of ram_local_responder against a cycle-indexed model.
// Latency: n/a.
// Backpressure: requests are held until ready is seen high.
module tb_ram_local_responder;

    localparam int DL = 10;
    localparam int IC = 16;
    localparam int RL = 3;
    localparam int RI = 200;
    localparam int RC = 8;

    logic        phy_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] local_address = '0;
    logic        local_write_req = 1'b0;
    logic        local_read_req = 1'b0;
    logic        local_burstbegin = 1'b0;
    logic [31:0] local_wdata = '0;
    logic [3:0]  local_be = '0;
    logic [2:0]  local_size = 3'd1;
    logic        local_ready;
    logic [31:0] local_rdata;
    logic        local_rdata_valid;
    logic        local_init_done;
    logic        local_refresh_ack;
    logic [1:0]  err_flags;

    ram_local_responder #(
        .DEPTH_LOG2(DL), .INIT_CYCLES(IC), .READ_LATENCY(RL),
        .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .phy_clk(phy_clk), .reset_n(reset_n),
        .local_address(local_address), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
        .local_wdata(local_wdata), .local_be(local_be), .local_size(local_size),
        .local_ready(local_ready), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid), .local_init_done(local_init_done),
        .local_refresh_ack(local_refresh_ack), .err_flags(err_flags)
    );

    initial forever #5 phy_clk = ~phy_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t = cycles since reset release (cycle k follows the k-th edge with reset high).
    typedef struct packed { int unsigned cyc; logic [31:0] d; } ent_t;

    int unsigned t = 0;
    logic [31:0] mem_m [0:(1<<DL)-1];
    ent_t        q[$];
    logic [1:0]  err_m = 2'b00;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_rdata = '0;

    function automatic bit rdy_f(input int unsigned tt);
        if (tt < IC + 1) return 1'b0;
        if (RI == 0) return 1'b1;
        return ((tt - (IC + 1)) % (RI + RC)) < RI;
    endfunction

    function automatic bit ack_f(input int unsigned tt);
        if (tt < IC + 1) return 1'b0;
        if (RI == 0) return 1'b0;
        return ((tt - (IC + 1)) % (RI + RC)) == (RI + RC - 1);
    endfunction

    initial forever begin
        @(posedge phy_clk or negedge reset_n);
        if (!reset_n) begin
            t = 0;
            q.delete();
            err_m = 2'b00;
            exp_valid = 1'b0;
            exp_rdata = '0;
        end else begin
            if (rdy_f(t)) begin
                if (local_write_req) begin
                    for (int b = 0; b < 4; b++)
                        if (local_be[b]) mem_m[local_address[DL-1:0]][8*b +: 8] = local_wdata[8*b +: 8];
                    if (local_read_req) err_m[1] = 1'b1;
                    if (local_size != 3'd1) err_m[0] = 1'b1;
                end else if (local_read_req) begin
                    q.push_back('{cyc: t + 1 + RL, d: mem_m[local_address[DL-1:0]]});
                    if (local_size != 3'd1) err_m[0] = 1'b1;
                end
            end
            t++;
            exp_valid = 1'b0;
            if (q.size() > 0 && q[0].cyc == t) begin
                exp_valid = 1'b1;
                exp_rdata = q[0].d;
                void'(q.pop_front());
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge phy_clk);
        chk("ready",       {31'd0, local_ready},       {31'd0, rdy_f(t)});
        chk("init_done",   {31'd0, local_init_done},   {31'd0, (t >= IC + 1)});
        chk("refresh_ack", {31'd0, local_refresh_ack}, {31'd0, ack_f(t)});
        chk("rdata_valid", {31'd0, local_rdata_valid}, {31'd0, exp_valid});
        chk("rdata",       local_rdata,                exp_rdata);
        chk("err_flags",   {30'd0, err_flags},         {30'd0, err_m});
    end

    // Capture of valid pulses with a free-running negedge stamp.
    int unsigned ncyc = 0;
    ent_t        cap[$];
    initial forever begin
        @(negedge phy_clk);
        ncyc++;
        if (local_rdata_valid) cap.push_back('{cyc: ncyc, d: local_rdata});
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit w, input bit r, input logic [24:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [2:0] sz,
                         output int waits, output int ack_at, output int acc_cyc);
        bit got;
        waits = 0; ack_at = -1; acc_cyc = 0; got = 1'b0;
        local_write_req = w; local_read_req = r; local_address = a;
        local_wdata = d; local_be = be; local_size = sz; local_burstbegin = 1'b1;
        while (!got) begin
            @(negedge phy_clk); #1;
            got = local_ready;
            if (got) begin
                acc_cyc = int'(ncyc);
            end else begin
                if (local_refresh_ack) ack_at = waits;
                waits++;
                if (waits > 2000) begin
                    total++; bad++;
                    $display("FAIL issue_timeout: waited %0d cycles, want ready within 2000", waits);
                    got = 1'b1;
                end
            end
        end
        @(posedge phy_clk); #1;
        local_write_req = 1'b0; local_read_req = 1'b0; local_burstbegin = 1'b0; local_size = 3'd1;
    endtask

    task automatic wr(input logic [24:0] a, input logic [31:0] d, input logic [3:0] be);
        int w, k, c;
        issue(1'b1, 1'b0, a, d, be, 3'd1, w, k, c);
    endtask

    task automatic rd(input logic [24:0] a, output int c);
        int w, k;
        issue(1'b0, 1'b1, a, 32'd0, 4'd0, 3'd1, w, k, c);
    endtask

    task automatic wait_cap(input int n);
        int k;
        k = 0;
        while (cap.size() < n && k < 40) begin
            @(negedge phy_clk); #1;
            k++;
        end
    endtask

    // Edges with reset high until ready is seen (bounded).
    task automatic wait_init(output int c);
        c = 0;
        do begin
            @(posedge phy_clk); #1;
            c++;
        end while (!local_ready && c < 100);
    endtask

    // Move to the first cycle of a refresh stall (ready just dropped).
    task automatic to_refresh(output bit ok);
        int k;
        k = 0;
        while (local_ready && k < 300) begin
            @(posedge phy_clk); #1;
            k++;
        end
        ok = !local_ready;
    endtask

    // ---------------- main sequence ----------------
    int          c, acc, w, k;
    int          accs[5];
    bit          ok;
    int          op;
    logic [24:0] a, last_a;
    logic [31:0] d;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge phy_clk);
        #1 reset_n = 1'b1;

        // Ready and init_done rise together on the 17th edge after release.
        wait_init(c);
        chk("init_edges", c, 32'd17);
        chk("init_done_with_ready", {31'd0, local_init_done}, 32'd1);
        chk("err_after_reset", {30'd0, err_flags}, 32'd0);

        // Give every RAM word a known value.
        for (int i = 0; i < (1 << DL); i++) wr(25'(i), $urandom, 4'hF);

        // Basic write then read and its latency.
        wr(25'h005, 32'hDEADBEEF, 4'hF);
        cap.delete();
        rd(25'h005, acc);
        wait_cap(1);
        chk("basic_count", cap.size(), 32'd1);
        if (cap.size() > 0) begin
            chk("rd_latency", 32'(cap[0].cyc - acc - 1), 32'd3);
            chk("basic_data", cap[0].d, 32'hDEADBEEF);
        end

        // Byte-enable merge.
        wr(25'h010, 32'h11223344, 4'hF);
        wr(25'h010, 32'hAABBCCDD, 4'b0101);
        cap.delete();
        rd(25'h010, acc);
        wait_cap(1);
        chk("be_count", cap.size(), 32'd1);
        if (cap.size() > 0) chk("be_data", cap[0].d, 32'h11BB33DD);

        // Upper address bits alias.
        wr(25'h0400, 32'hCAFEF00D, 4'hF);
        cap.delete();
        rd(25'h000, acc);
        wait_cap(1);
        chk("alias_count", cap.size(), 32'd1);
        if (cap.size() > 0) chk("alias_data", cap[0].d, 32'hCAFEF00D);

        // Five back-to-back reads right after a refresh.
        for (int i = 0; i < 5; i++) wr(25'h020 + 25'(i), 32'hA5000000 + 32'(i), 4'hF);
        to_refresh(ok);
        chk("found_refresh_a", {31'd0, ok}, 32'd1);
        while (!local_ready && k < 50) begin @(posedge phy_clk); #1; k++; end
        cap.delete();
        for (int i = 0; i < 5; i++) rd(25'h020 + 25'(i), accs[i]);
        wait_cap(5);
        chk("burst_count", cap.size(), 32'd5);
        for (int i = 0; i < 5 && i < cap.size(); i++) begin
            chk("burst_data", cap[i].d, 32'hA5000000 + 32'(i));
            chk("burst_consecutive", cap[i].cyc, cap[0].cyc + 32'(i));
        end

        // Read and write together: write lands, read dropped.
        cap.delete();
        issue(1'b1, 1'b1, 25'h030, 32'h5A5A1234, 4'hF, 3'd1, w, k, acc);
        repeat (8) begin @(posedge phy_clk); #1; end
        chk("rw_no_valid", cap.size(), 32'd0);
        chk("rw_err", {30'd0, err_flags}, 32'd2);
        rd(25'h030, acc);
        wait_cap(1);
        if (cap.size() > 0) chk("rw_write_landed", cap[0].d, 32'h5A5A1234);

        // Oversized burst length is flagged and treated as a single beat.
        issue(1'b1, 1'b0, 25'h031, 32'h01020304, 4'hF, 3'd4, w, k, acc);
        cap.delete();
        rd(25'h031, acc);
        wait_cap(1);
        chk("size_err", {30'd0, err_flags}, 32'd3);
        chk("size_count", cap.size(), 32'd1);
        if (cap.size() > 0) chk("size_data", cap[0].d, 32'h01020304);

        // Reset with two reads in flight.
        cap.delete();
        rd(25'h010, acc);
        rd(25'h005, acc);
        reset_n = 1'b0;
        repeat (3) begin @(posedge phy_clk); #1; end
        chk("reset_err_clear", {30'd0, err_flags}, 32'd0);
        reset_n = 1'b1;
        wait_init(c);
        chk("reinit_edges", c, 32'd17);
        chk("reset_no_valid", cap.size(), 32'd0);
        rd(25'h010, acc);
        rd(25'h005, acc);
        wait_cap(2);
        chk("retain_count", cap.size(), 32'd2);
        if (cap.size() > 1) begin
            chk("retain_data0", cap[0].d, 32'h11BB33DD);
            chk("retain_data1", cap[1].d, 32'hDEADBEEF);
        end

        // Randomized traffic; the per-cycle compare does the checking.
        last_a = '0;
        for (int n = 0; n < 2500; n++) begin
            op = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) a = last_a;
            else a = 25'($urandom);
            d = $urandom;
            if (op < 45) begin
                issue(1'b1, 1'b0, a, d, 4'($urandom), ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'd1, w, k, acc);
            end else if (op < 90) begin
                issue(1'b0, 1'b1, a, 32'd0, 4'd0, ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'd1, w, k, acc);
            end else if (op < 93) begin
                issue(1'b1, 1'b1, a, d, 4'($urandom), 3'd1, w, k, acc);
            end else begin
                repeat ($urandom_range(1, 3)) begin @(posedge phy_clk); #1; end
            end
            last_a = a;
        end

        // Read held across a refresh: stall length and ack position.
        to_refresh(ok);
        chk("found_refresh_b", {31'd0, ok}, 32'd1);
        issue(1'b0, 1'b1, 25'h005, 32'd0, 4'd0, 3'd1, w, k, acc);
        chk("refresh_low_cycles", w, 32'd8);
        chk("refresh_ack_pos", k, 32'd7);

        repeat (20) begin @(posedge phy_clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
